// File: rtl/io_adr_dec_wait_if.sv
// Core-side I/O bus between the AVR core and the I/O read decoder.
// The core is the master: it drives the address, strobes and write data,
// and gets back the read data and the stall request.
interface io_adr_dec_wait_if;
    logic [5:0] adr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbusout;
    logic [7:0] dbusin_int;
    logic       cpuwait;

    modport master (
        output adr, iore, iowe, dbusout,
        input  dbusin_int, cpuwait
    );

    modport slave (
        input  adr, iore, iowe, dbusout,
        output dbusin_int, cpuwait
    );
endinterface

// File: rtl/io_adr_dec_wait.sv
// I/O read decoder/multiplexer for the AVR core.
// Returns SPL/SPH/SREG, owns the optional RAMPZ/EIND registers, arbitrates
// N_CH external read channels by priority (lowest index wins) and stretches
// slow external reads with a wait-state FSM that gives up after TMO_CYC
// cycles, recording the event in a sticky error flag.
module io_adr_dec_wait #(
    parameter int unsigned N_CH       = 4,
    parameter bit          RAMPZ_EN   = 1'b1,
    parameter bit          EIND_EN    = 1'b0,
    parameter logic [7:0]  RAMPZ_MASK = 8'h01,
    parameter bit          WAIT_EN    = 1'b1,
    parameter int unsigned TMO_CYC    = 15,
    parameter logic [5:0]  ERR_ADR    = 6'h3A
) (
    input  logic                cp2,
    input  logic                ireset,
    io_adr_dec_wait_if.slave    bus,
    input  logic [7:0]          spl_out,
    input  logic [7:0]          sph_out,
    input  logic [7:0]          sreg_out,
    input  logic [8*N_CH-1:0]   ext_dbus,
    input  logic [N_CH-1:0]     ext_out_en,
    input  logic                ext_rdy,
    output logic [7:0]          rampz_out,
    output logic [7:0]          eind_out,
    output logic                io_tmo_err
);

    localparam int CW = $clog2(TMO_CYC + 1);

    localparam logic [5:0] ADR_RAMPZ = 6'h3B;
    localparam logic [5:0] ADR_EIND  = 6'h3C;
    localparam logic [5:0] ADR_SPL   = 6'h3D;
    localparam logic [5:0] ADR_SPH   = 6'h3E;
    localparam logic [5:0] ADR_SREG  = 6'h3F;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    rampz, eind;
    logic          tmo_err;
    logic          tmo_set;
    logic          is_int, ext_rd;
    logic [7:0]    ext_val, rd_val, dbus_c;
    logic          cpuwait_c;

    // Address class: the fixed core registers, the error register and any
    // enabled RAMPZ/EIND are internal; everything else goes to the channels.
    always_comb begin
        is_int = (bus.adr == ADR_SPL) || (bus.adr == ADR_SPH) ||
                 (bus.adr == ADR_SREG) || (bus.adr == ERR_ADR) ||
                 (RAMPZ_EN && (bus.adr == ADR_RAMPZ)) ||
                 (EIND_EN && (bus.adr == ADR_EIND));
        ext_rd = bus.iore && !is_int;
    end

    // Priority select: scan high to low so the lowest enabled channel lands last.
    always_comb begin
        ext_val = 8'hFF;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ext_out_en[i]) ext_val = ext_dbus[8*i +: 8];
        end
    end

    // Read mux; registers are read before any same-cycle write lands.
    always_comb begin
        rd_val = 8'h00;
        if (bus.iore) begin
            if (!is_int)                  rd_val = ext_val;
            else if (bus.adr == ERR_ADR)  rd_val = {7'b0, tmo_err};
            else begin
                case (bus.adr)
                    ADR_SPL:   rd_val = spl_out;
                    ADR_SPH:   rd_val = sph_out;
                    ADR_SREG:  rd_val = sreg_out;
                    ADR_RAMPZ: rd_val = rampz;
                    ADR_EIND:  rd_val = eind;
                    default:   rd_val = 8'h00;
                endcase
            end
        end
    end

    // Wait FSM next state and outputs. A timeout completes the access with
    // 8'hFF; a dropped iore abandons it without flagging an error.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cpuwait_c = 1'b0;
        tmo_set   = 1'b0;
        dbus_c    = rd_val;
        case (state)
            S_IDLE: begin
                if (WAIT_EN && ext_rd && !ext_rdy) begin
                    cpuwait_c = 1'b1;
                    cnt_nx    = CW'(1);
                    state_nx  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.iore || ext_rdy) begin
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else if (cnt == CW'(TMO_CYC)) begin
                    dbus_c   = 8'hFF;
                    tmo_set  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    cpuwait_c = 1'b1;
                    cnt_nx    = cnt + CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (ireset) begin
            cpuwait_c = 1'b0;
            dbus_c    = 8'h00;
        end
    end

    assign bus.cpuwait    = cpuwait_c;
    assign bus.dbusin_int = dbus_c;

    // FSM state and wait counter.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // RAMPZ/EIND registers; disabled ones never leave their reset value.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            rampz <= 8'h00;
            eind  <= 8'h00;
        end else if (bus.iowe) begin
            if (RAMPZ_EN && (bus.adr == ADR_RAMPZ)) rampz <= bus.dbusout & RAMPZ_MASK;
            if (EIND_EN && (bus.adr == ADR_EIND))   eind  <= bus.dbusout;
        end
    end

    // Sticky timeout flag; a new timeout beats a coincident software clear.
    always_ff @(posedge cp2) begin
        if (ireset)
            tmo_err <= 1'b0;
        else if (tmo_set)
            tmo_err <= 1'b1;
        else if (bus.iowe && (bus.adr == ERR_ADR) && bus.dbusout[0])
            tmo_err <= 1'b0;
    end

    assign rampz_out  = RAMPZ_EN ? rampz : 8'h00;
    assign eind_out   = EIND_EN ? eind : 8'h00;
    assign io_tmo_err = tmo_err;

endmodule

// File: doc/io_adr_dec_wait.md
Name: io_adr_dec_wait

Overview:
- Parametrised successor of the AVR core's internal I/O read decoder/multiplexer.
- Decodes the 6-bit I/O address and returns SPL/SPH/SREG from the core.
- Owns the RAMPZ and EIND registers (write and read), each optional.
- Arbitrates N external peripheral read channels by priority.
- Adds a wait-state handshake with timeout for slow peripherals, plus a sticky timeout-error register.
- Sits between the core's I/O read bus and the peripheral read buses.

Parameters:
- N_CH, 4: number of external read channels (1..8).
- RAMPZ_EN, 1: RAMPZ register implemented at 6'h3B.
- EIND_EN, 0: EIND register implemented at 6'h3C.
- RAMPZ_MASK, 8'h01: writable bits of RAMPZ. Unwritable bits read 0.
- WAIT_EN, 1: enables the wait-state FSM. When 0, ext_rdy is ignored and external reads are zero-wait.
- TMO_CYC, 15: maximum number of wait cycles before timeout (1..255).
- ERR_ADR, 6'h3A: address of the error/status register.

Ports:
- cp2  in  1  clock
- ireset  in  1  reset; synchronous, active-high
- adr  in  6  I/O address
- iore  in  1  I/O read strobe
- iowe  in  1  I/O write strobe
- dbusout  in  8  core write data
- spl_out  in  8  stack pointer low
- sph_out  in  8  stack pointer high
- sreg_out  in  8  status register
- ext_dbus  in  8*N_CH  external channel read data; channel i occupies bits [8i+7:8i]
- ext_out_en  in  N_CH  channel i decodes the current adr
- ext_rdy  in  1  external read data valid this cycle
- dbusin_int  out  8  read data to the core
- cpuwait  out  1  stall request to the core
- rampz_out  out  8  RAMPZ register
- eind_out  out  8  EIND register
- io_tmo_err  out  1  sticky timeout flag

Behaviour:

Reset:
- While ireset=1 at a clock edge:
  - rampz, eind, io_tmo_err, wait counter <= 0.
  - FSM <= IDLE.
- While ireset=1, outputs are forced: cpuwait=0, dbusin_int=8'h00.

Address classes:
- Internal: 3D, 3E, 3F, ERR_ADR.
- 3B is internal only if RAMPZ_EN=1; 3C is internal only if EIND_EN=1.
- Every other address is external.
- int_rd = iore & internal. ext_rd = iore & external.

Read mux (combinational, same cycle):
- 3D returns spl_out, 3E returns sph_out, 3F returns sreg_out.
- 3B returns rampz, 3C returns eind.
- ERR_ADR returns {7'b0, io_tmo_err}.
- External reads return ext_dbus of the lowest-index channel with ext_out_en=1.
- If no channel is enabled, the result is 8'hFF.
- If iore=0, dbusin_int=8'h00.

Writes (registered on cp2 when iowe=1):
- 3B (RAMPZ_EN=1): rampz <= dbusout & RAMPZ_MASK.
- 3C (EIND_EN=1): eind <= dbusout.
- ERR_ADR: dbusout[0]=1 clears io_tmo_err.
- If a timeout set and a clear occur in the same cycle, the set wins.
- Disabled registers: outputs tie to 0 and writes to them are ignored.
- iore and iowe asserted together: the read returns the pre-write value.

Wait FSM (WAIT_EN=1). States IDLE, WAIT; counter cnt has width clog2(TMO_CYC+1).
- IDLE:
  - ext_rd & !ext_rdy: cpuwait=1 (combinational), cnt <= 1, next state WAIT.
  - Otherwise: cpuwait=0, read completes this cycle.
- WAIT:
  - ext_rdy=1: cpuwait=0, dbusin_int = mux result, cnt <= 0, next state IDLE.
  - ext_rdy=0 and cnt==TMO_CYC: cpuwait=0, dbusin_int=8'hFF, io_tmo_err <= 1, cnt <= 0, next state IDLE.
  - Otherwise: cpuwait=1, cnt <= cnt+1.
  - iore drops while in WAIT (aborted access): cpuwait=0, next state IDLE, no error set.
- Maximum stall is TMO_CYC cycles. Internal reads never stall.
- The core holds adr and iore stable while cpuwait=1.
- A new external read may begin in the cycle after a completion (back-to-back), restarting from IDLE.
- Reset asserted while in WAIT: FSM returns to IDLE and io_tmo_err is cleared.

Test Plan:
1. Reset, then iore=1, adr=3D, spl_out=8'h5A -> dbusin_int=8'h5A in the same cycle; cpuwait=0; rampz_out=0; io_tmo_err=0.
2. iowe=1, adr=3B, dbusout=8'hFF (RAMPZ_MASK=8'h01) -> rampz_out=8'h01 on the next cycle; reading 3B returns 8'h01. With EIND_EN=0, a write to 3C leaves eind_out=0, and a read of 3C follows the external path.
3. ext_out_en=4'b0110, ch1=8'h11, ch2=8'h22, adr=10, ext_rdy=1 -> dbusin_int=8'h11, no stall. ext_out_en=0 -> dbusin_int=8'hFF.
4. External read with ext_rdy low for 3 cycles, then high with ch0=8'hC3 -> cpuwait=1 for exactly 3 cycles, then cpuwait=0 with dbusin_int=8'hC3; io_tmo_err stays 0.
5. External read with ext_rdy stuck low, TMO_CYC=15 -> cpuwait=1 for 15 cycles; on the 16th cycle cpuwait=0, dbusin_int=8'hFF, and io_tmo_err=1 on the next cycle. Reading ERR_ADR returns 8'h01. Writing 8'h01 to ERR_ADR clears it; a clear coincident with a new timeout leaves io_tmo_err=1.
6. ireset asserted during WAIT at cnt=5 -> next cycle: FSM in IDLE, cpuwait=0, dbusin_int=0, rampz_out=0. A following external read with ext_rdy=0 restarts the stall with cnt=1.
